// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// datapath width, reset PC and sequential PC increment.
package if_pkg;

    localparam int          INST_W       = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_sat_counter.sv
// Saturating event counter; holds at all-ones once reached.
module if_sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request, registered hand-off
// to decode, redirect handling with in-flight discard. Optional perf counters: IF_FETCH_PERF_EN.
//
// state | meaning
// IDLE  | out of reset, first request not yet issued
// REQ   | imem request outstanding at req_addr
// VALID | captured word presented to decode
module if_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = if_pkg::RESET_PC_DEF,
    parameter int          INST_W   = if_pkg::INST_W
) (
    input  logic              CLK,
    input  logic              Reset,
    output logic              imem_req,
    output logic [INST_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [INST_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INST_W-1:0] id_inst,
    output logic [INST_W-1:0] id_pc,
    output logic              busy
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_wait_cnt,
    output logic [31:0]       perf_drop_cnt
`endif
);

    import if_pkg::*;

    fetch_state_t      state, state_nxt;
    logic [INST_W-1:0] pc, pc_nxt;
    logic [INST_W-1:0] req_addr, req_addr_nxt;
    logic              drop, drop_nxt;
    logic [INST_W-1:0] id_inst_nxt, id_pc_nxt;
    logic [INST_W-1:0] tgt;

    assign tgt = redirect_pc & ~INST_W'(3);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            pc       <= INST_W'(RESET_PC);
            req_addr <= INST_W'(RESET_PC);
            drop     <= 1'b0;
            id_inst  <= '0;
            id_pc    <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            req_addr <= req_addr_nxt;
            drop     <= drop_nxt;
            id_inst  <= id_inst_nxt;
            id_pc    <= id_pc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        drop_nxt     = drop;
        id_inst_nxt  = id_inst;
        id_pc_nxt    = id_pc;
        case (state)
            IDLE: begin
                state_nxt = REQ;
                if (redirect) begin
                    pc_nxt       = tgt;
                    req_addr_nxt = tgt;
                end else begin
                    req_addr_nxt = pc;
                end
            end
            REQ: begin
                if (redirect) begin
                    pc_nxt = tgt;
                    // A word landing with the redirect is simply dropped; otherwise
                    // the outstanding request must finish before the target is issued.
                    if (imem_ready) begin
                        req_addr_nxt = tgt;
                        drop_nxt     = 1'b0;
                    end else begin
                        drop_nxt     = 1'b1;
                    end
                end else if (imem_ready) begin
                    if (drop) begin
                        drop_nxt     = 1'b0;
                        req_addr_nxt = pc;
                    end else begin
                        id_inst_nxt = imem_rdata;
                        id_pc_nxt   = req_addr;
                        pc_nxt      = req_addr + INST_W'(PC_STEP);
                        state_nxt   = VALID;
                    end
                end
            end
            VALID: begin
                if (id_ready || redirect) begin
                    state_nxt = REQ;
                    if (redirect) begin
                        pc_nxt       = tgt;
                        req_addr_nxt = tgt;
                    end else begin
                        req_addr_nxt = pc;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign imem_req  = (state == REQ);
    assign imem_addr = req_addr;
    assign id_valid  = (state == VALID);
    assign busy      = (state != IDLE);

`ifdef IF_FETCH_PERF_EN
    logic discard;
    assign discard = imem_req && imem_ready && (redirect || drop);

    if_sat_counter #(.W(32)) u_wait_cnt (
        .CLK   (CLK),
        .Reset (Reset),
        .inc   (imem_req && !imem_ready),
        .cnt   (perf_wait_cnt)
    );

    if_sat_counter #(.W(32)) u_drop_cnt (
        .CLK   (CLK),
        .Reset (Reset),
        .inc   (discard),
        .cnt   (perf_drop_cnt)
    );
`endif

endmodule

// File: tb/tb_if_fetch_sequencer.sv
// Directed bench for if_fetch_sequencer; expected requests and decode words are
// queued by the stimulus and checked by monitors on the falling edge.
module tb_if_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        busy;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } out_t;

    logic [31:0] exp_req_q[$];
    out_t        exp_out_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mon_addr;
    out_t        mon_out;

    if_fetch_sequencer dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Memory side scoreboard: every accepted request address is checked in order.
    always @(negedge CLK) begin
        if (imem_req && imem_ready) begin
            if (exp_req_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL req_unexpected: got addr %h expected no request", imem_addr);
            end else begin
                mon_addr = exp_req_q.pop_front();
                chk("req_addr", imem_addr, mon_addr);
            end
        end
        if (id_valid && id_ready) begin
            if (exp_out_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL id_unexpected: got inst %h pc %h expected none", id_inst, id_pc);
            end else begin
                mon_out = exp_out_q.pop_front();
                chk("id_inst", id_inst, mon_out.inst);
                chk("id_pc", id_pc, mon_out.pc);
            end
        end
    end

    task automatic push_out(input logic [31:0] inst, input logic [31:0] pc);
        out_t o;
        o.inst = inst;
        o.pc   = pc;
        exp_out_q.push_back(o);
    endtask

    // Serve the request at addr after 'waits' stall cycles, checking it is held.
    task automatic fetch(input logic [31:0] addr, input int waits, input logic [31:0] data);
        exp_req_q.push_back(addr);
        imem_ready = 1'b0;
        for (int k = 0; k < waits; k++) begin
            chk1("req_held", imem_req, 1'b1);
            chk("addr_held", imem_addr, addr);
            step();
        end
        chk1("req_now", imem_req, 1'b1);
        chk("addr_now", imem_addr, addr);
        imem_ready = 1'b1;
        imem_rdata = data;
        step();
        imem_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk1("rst_imem_req", imem_req, 1'b0);
        chk1("rst_id_valid", id_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk("rst_id_inst", id_inst, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);

        Reset = 1'b1;
        step();
        chk1("busy_after_idle", busy, 1'b1);
        chk("first_addr", imem_addr, 32'h0000_3000);

        // zero-wait memory, decode always ready: one word every two cycles
        for (int i = 0; i < 3; i++) begin
            exp_req_q.push_back(32'h3000 + 32'(4 * i));
            push_out(32'h2001_0001, 32'h3000 + 32'(4 * i));
            imem_ready = 1'b1;
            imem_rdata = 32'h2001_0001;
            id_ready   = 1'b1;
            step();
            chk1("t1_valid_hi", id_valid, 1'b1);
            chk1("t1_req_lo", imem_req, 1'b0);
            step();
            chk1("t1_valid_lo", id_valid, 1'b0);
            chk1("t1_req_hi", imem_req, 1'b1);
        end
        imem_ready = 1'b0;
        id_ready   = 1'b0;

        // three wait states, then decode stalls five cycles
        fetch(32'h300C, 3, 32'hA000_300C);
        chk1("t2_valid", id_valid, 1'b1);
        push_out(32'hA000_300C, 32'h300C);
        for (int i = 0; i < 5; i++) begin
            step();
            chk1("t4_valid", id_valid, 1'b1);
            chk("t4_inst", id_inst, 32'hA000_300C);
            chk("t4_pc", id_pc, 32'h300C);
            chk1("t4_no_req", imem_req, 1'b0);
        end
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        chk1("t4_valid_lo", id_valid, 1'b0);
        chk("t4_next_addr", imem_addr, 32'h3010);

        // redirect while waiting: in-flight word is dropped
        exp_req_q.push_back(32'h3010);
        step();
        redirect = 1'b1;
        redirect_pc = 32'h3040;
        step();
        redirect = 1'b0;
        chk("t3_addr_kept", imem_addr, 32'h3010);
        chk1("t3_req_kept", imem_req, 1'b1);
        step();
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ready = 1'b0;
        chk1("t3_no_valid", id_valid, 1'b0);
        chk("t3_redir_addr", imem_addr, 32'h3040);
        chk1("t3_req_hi", imem_req, 1'b1);

        // redirect in VALID without handshake kills the word
        fetch(32'h3040, 0, 32'hB000_3040);
        chk1("t5a_valid", id_valid, 1'b1);
        redirect = 1'b1;
        redirect_pc = 32'h3100;
        step();
        redirect = 1'b0;
        chk1("t5a_killed", id_valid, 1'b0);
        chk("t5a_addr", imem_addr, 32'h3100);

        // redirect coinciding with handshake: word consumed
        fetch(32'h3100, 0, 32'hC000_3100);
        push_out(32'hC000_3100, 32'h3100);
        redirect = 1'b1;
        redirect_pc = 32'h3200;
        id_ready = 1'b1;
        step();
        redirect = 1'b0;
        id_ready = 1'b0;
        chk1("t5b_valid_lo", id_valid, 1'b0);
        chk("t5b_addr", imem_addr, 32'h3200);

        // redirect together with imem_ready, then PC wrap
        exp_req_q.push_back(32'h3200);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        redirect = 1'b0;
        imem_ready = 1'b0;
        chk1("t6_no_valid", id_valid, 1'b0);
        chk("t6_addr", imem_addr, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 1, 32'hD000_0001);
        push_out(32'hD000_0001, 32'hFFFF_FFFC);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        chk("t6_wrap_addr", imem_addr, 32'h0000_0000);

        // two redirects during one drop; last wins, low bits masked
        exp_req_q.push_back(32'h0);
        redirect = 1'b1;
        redirect_pc = 32'h5000;
        step();
        redirect_pc = 32'h3043;
        step();
        redirect = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ready = 1'b0;
        chk1("t7_no_valid", id_valid, 1'b0);
        chk("t7_addr", imem_addr, 32'h3040);
        fetch(32'h3040, 0, 32'hE000_3040);
        chk1("t7_single_drop", id_valid, 1'b1);
        push_out(32'hE000_3040, 32'h3040);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        chk("t7_next_addr", imem_addr, 32'h3044);

        // reset mid-request, then redirect in IDLE
        step();
        Reset = 1'b0;
        #1;
        chk1("t8_req_lo", imem_req, 1'b0);
        chk1("t8_busy_lo", busy, 1'b0);
        chk("t8_id_inst", id_inst, 32'h0);
        chk("t8_id_pc", id_pc, 32'h0);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        step();
        chk1("t8_req_still_lo", imem_req, 1'b0);
        imem_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h3083;
        Reset = 1'b1;
        step();
        redirect = 1'b0;
        chk1("t8_busy", busy, 1'b1);
        chk("t8_idle_redir", imem_addr, 32'h3080);
        fetch(32'h3080, 2, 32'hF000_3080);
        push_out(32'hF000_3080, 32'h3080);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        step();

        chk("req_queue_left", 32'(exp_req_q.size()), 32'h0);
        chk("out_queue_left", 32'(exp_out_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
